// File: rtl/strt_validator.sv
// strt_validator
//   Start-bit validator for the UART RX path. The raw line is synchronised, a
//   falling edge opens a one-bit window, and a majority vote of VOTE_SAMPLES
//   samples centred on mid-bit decides between a valid start and a glitch.
//   After a valid start the block stays locked until the frame handler
//   reports frame_done.
//
//   Ports
//     clk            system clock
//     rst            asynchronous reset, active-low
//     rx_in          raw serial line, idle high
//     enable         block enable; low forces IDLE and drops any vote in flight
//     prescale       oversampling ticks per bit, captured on the start edge
//     frame_done     pulse from the frame handler, releases LOCKED
//     glitch_cnt_clr synchronous clear of glitch_cnt (wins over an increment)
//     strt_valid     1-cycle pulse, start bit accepted
//     strt_glitch    1-cycle pulse, start bit rejected
//     busy           high in COUNT or LOCKED
//     cfg_err        last start edge arrived with prescale < 2*VOTE_SAMPLES
//     glitch_cnt     saturating count of rejected start bits
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for a falling edge on the synchronised line
//   ST_COUNT | counting ticks through the start bit, voting around mid-bit
//   ST_LOCKED| start accepted; edges ignored until frame_done
module strt_validator #(
  parameter int PRESC_W      = 6,
  parameter int SYNC_STAGES  = 2,
  parameter int VOTE_SAMPLES = 3,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               frame_done,
  input  logic               glitch_cnt_clr,
  output logic               strt_valid,
  output logic               strt_glitch,
  output logic               busy,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   glitch_cnt
);

  localparam int ZW = $clog2(VOTE_SAMPLES + 1);
  localparam logic [PRESC_W:0] MIN_PRESC = (PRESC_W+1)'(2 * VOTE_SAMPLES);
  localparam logic [PRESC_W:0] HALF_WIN  = (PRESC_W+1)'((VOTE_SAMPLES - 1) / 2);
  localparam logic [ZW-1:0]    MAJ       = ZW'(VOTE_SAMPLES / 2);

  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [PRESC_W-1:0]     tick_q, tick_d;
  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic [ZW-1:0]          zero_q, zero_d;
  logic                   valid_q, valid_d;
  logic                   glitch_q, glitch_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]       gcnt_q, gcnt_d;
  logic                   gcnt_inc;

  logic                   rx_sync;
  logic                   fall_edge;
  logic [PRESC_W:0]       mid_x, win_lo, win_hi, tick_x;
  logic                   in_win;
  logic                   last_tick;
  logic [ZW-1:0]          zeros_now;

  assign rx_sync   = sync_q[SYNC_STAGES-1];
  assign fall_edge = prev_q & ~rx_sync;
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], rx_in};
  assign prev_d    = rx_sync;

  // Window arithmetic is one bit wider so mid+half cannot wrap.
  assign mid_x     = {1'b0, presc_q >> 1};
  assign win_lo    = mid_x - HALF_WIN;
  assign win_hi    = mid_x + HALF_WIN;
  assign tick_x    = {1'b0, tick_q};
  assign in_win    = (tick_x >= win_lo) && (tick_x <= win_hi);
  assign last_tick = (tick_q == presc_q - PRESC_W'(1));
  // The decision tick may itself be a sample tick (VOTE_SAMPLES=1), so fold
  // the current sample in before comparing.
  assign zeros_now = zero_q + ZW'(in_win & ~rx_sync);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    presc_d   = presc_q;
    zero_d    = zero_q;
    valid_d   = 1'b0;
    glitch_d  = 1'b0;
    cfg_err_d = cfg_err_q;
    gcnt_inc  = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      tick_d  = '0;
      zero_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fall_edge) begin
            if ({1'b0, prescale} < MIN_PRESC) begin
              cfg_err_d = 1'b1;
            end else begin
              cfg_err_d = 1'b0;
              presc_d   = prescale;
              tick_d    = PRESC_W'(1);
              zero_d    = '0;
              state_d   = ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          tick_d = tick_q + PRESC_W'(1);
          zero_d = zeros_now;
          if (last_tick) begin
            tick_d = '0;
            zero_d = '0;
            if (zeros_now > MAJ) begin
              valid_d = 1'b1;
              state_d = ST_LOCKED;
            end else begin
              glitch_d = 1'b1;
              gcnt_inc = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
        ST_LOCKED: begin
          if (frame_done) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    gcnt_d = gcnt_q;
    if (glitch_cnt_clr) gcnt_d = '0;
    else if (gcnt_inc && (gcnt_q != '1)) gcnt_d = gcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sync_q    <= '1;
      prev_q    <= 1'b1;
      tick_q    <= '0;
      presc_q   <= '0;
      zero_q    <= '0;
      valid_q   <= 1'b0;
      glitch_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      gcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      tick_q    <= tick_d;
      presc_q   <= presc_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
      glitch_q  <= glitch_d;
      cfg_err_q <= cfg_err_d;
      gcnt_q    <= gcnt_d;
    end
  end

  assign strt_valid  = valid_q;
  assign strt_glitch = glitch_q;
  assign busy        = (state_q == ST_COUNT) || (state_q == ST_LOCKED);
  assign cfg_err     = cfg_err_q;
  assign glitch_cnt  = gcnt_q;

endmodule

// File: tb/tb_strt_validator.sv
// Directed bench for strt_validator. Drive cycle c starts 1 ns after a rising
// edge; rx_in driven in cycle c is seen by the vote in tick c, and the
// pulse for prescale p lands in drive cycle 2+p (edge-detect cycle is 2).
module tb_strt_validator;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       enable;
  logic [5:0] prescale;
  logic       frame_done;
  logic       glitch_cnt_clr;
  logic       strt_valid;
  logic       strt_glitch;
  logic       busy;
  logic       cfg_err;
  logic [7:0] glitch_cnt;

  int n_total = 0;
  int n_bad   = 0;

  int   v_at, g_at, v_cnt, g_cnt;
  logic busy_p;

  always #5 clk = ~clk;

  strt_validator #(
    .PRESC_W(6), .SYNC_STAGES(2), .VOTE_SAMPLES(3), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .enable(enable),
    .prescale(prescale), .frame_done(frame_done),
    .glitch_cnt_clr(glitch_cnt_clr), .strt_valid(strt_valid),
    .strt_glitch(strt_glitch), .busy(busy), .cfg_err(cfg_err),
    .glitch_cnt(glitch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) step();
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
  endtask

  // hmask bit c = rx_in level in drive cycle c (bit 0 must be 0 for the fall).
  task automatic run_start(input int p, input logic [31:0] hmask, input int ncyc,
                           input int dis_at, input int clr_at, input int rst_at,
                           input int probe,
                           output int va, output int ga, output int vc, output int gc,
                           output logic bp);
    va = -1; ga = -1; vc = 0; gc = 0; bp = 1'bx;
    for (int c = 0; c < ncyc; c++) begin
      rx_in          = (c < 32) ? hmask[c] : 1'b1;
      prescale       = 6'(p);
      enable         = (c != dis_at);
      glitch_cnt_clr = (c == clr_at);
      rst            = (c != rst_at);
      @(negedge clk);
      if (strt_valid) begin vc++; if (va < 0) va = c; end
      if (strt_glitch) begin gc++; if (ga < 0) ga = c; end
      if (c == probe) bp = busy;
      step();
    end
    rx_in = 1'b1; enable = 1'b1; glitch_cnt_clr = 1'b0; rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; rx_in = 1'b1; enable = 1'b1; prescale = 6'd8;
    frame_done = 1'b0; glitch_cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(strt_valid), 0);
    chk("rst_glitch", 32'(strt_glitch), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_gcnt", 32'(glitch_cnt), 0);
    step();
    idle(3);

    // clean start bit
    run_start(8, 32'hFFFF_FF00, 14, -1, -1, -1, 5, v_at, g_at, v_cnt, g_cnt, busy_p);
    chk("valid_at", 32'(v_at), 10);
    chk("valid_cnt", 32'(v_cnt), 1);
    chk("valid_no_glitch", 32'(g_cnt), 0);
    chk("valid_busy_count", 32'(busy_p), 1);
    idle(5);
    @(negedge clk);
    chk("locked_busy", 32'(busy), 1);
    step();
    pulse_frame_done();
    @(negedge clk);
    chk("release_busy", 32'(busy), 0);
    step();
    idle(3);

    // short low: glitch
    run_start(8, 32'hFFFF_FFFC, 14, -1, -1, -1, -1, v_at, g_at, v_cnt, g_cnt, busy_p);
    chk("short_glitch_at", 32'(g_at), 10);
    chk("short_glitch_cnt", 32'(g_cnt), 1);
    chk("short_no_valid", 32'(v_cnt), 0);
    @(negedge clk);
    chk("short_gcnt", 32'(glitch_cnt), 1);
    chk("short_busy", 32'(busy), 0);
    step();
    idle(3);

    // high on tick 4 only: 2 of 3 zeros
    run_start(8, 32'hFFFF_FF10, 14, -1, -1, -1, -1, v_at, g_at, v_cnt, g_cnt, busy_p);
    chk("vote21_valid_at", 32'(v_at), 10);
    chk("vote21_no_glitch", 32'(g_cnt), 0);
    pulse_frame_done();
    idle(3);

    // high on ticks 4,5: 1 of 3 zeros
    run_start(8, 32'hFFFF_FF30, 14, -1, -1, -1, -1, v_at, g_at, v_cnt, g_cnt, busy_p);
    chk("vote12_glitch_at", 32'(g_at), 10);
    chk("vote12_no_valid", 32'(v_cnt), 0);
    @(negedge clk);
    chk("vote12_gcnt", 32'(glitch_cnt), 2);
    step();
    idle(3);

    // enable dropped at tick 3 (drive cycle 5)
    run_start(8, 32'hFFFF_C000, 16, 5, -1, -1, 6, v_at, g_at, v_cnt, g_cnt, busy_p);
    chk("dis_no_valid", 32'(v_cnt), 0);
    chk("dis_no_glitch", 32'(g_cnt), 0);
    chk("dis_busy_after", 32'(busy_p), 0);
    idle(3);

    // illegal prescale
    run_start(4, 32'hFFFF_FF00, 14, -1, -1, -1, 3, v_at, g_at, v_cnt, g_cnt, busy_p);
    chk("p4_no_pulse", 32'(v_cnt + g_cnt), 0);
    chk("p4_busy", 32'(busy_p), 0);
    @(negedge clk);
    chk("p4_cfg_err", 32'(cfg_err), 1);
    step();
    idle(3);

    // prescale 16 recovers
    run_start(16, 32'hFFFF_0000, 22, -1, -1, -1, -1, v_at, g_at, v_cnt, g_cnt, busy_p);
    chk("p16_valid_at", 32'(v_at), 18);
    chk("p16_valid_cnt", 32'(v_cnt), 1);
    @(negedge clk);
    chk("p16_cfg_err", 32'(cfg_err), 0);
    step();
    pulse_frame_done();
    idle(3);

    // saturation: 256 more glitches on top of the 2 already counted
    for (int k = 0; k < 256; k++) begin
      run_start(6, 32'hFFFF_FFFE, 10, -1, -1, -1, -1, v_at, g_at, v_cnt, g_cnt, busy_p);
      idle(3);
    end
    @(negedge clk);
    chk("sat_gcnt", 32'(glitch_cnt), 255);
    step();

    // clear in the decision cycle (tick 5 -> drive cycle 7) beats the increment
    run_start(6, 32'hFFFF_FFFE, 10, -1, 7, -1, -1, v_at, g_at, v_cnt, g_cnt, busy_p);
    chk("clr_glitch_at", 32'(g_at), 8);
    @(negedge clk);
    chk("clr_gcnt", 32'(glitch_cnt), 0);
    step();
    idle(3);

    // edge during LOCKED ignored
    run_start(8, 32'hFFFF_FF00, 14, -1, -1, -1, -1, v_at, g_at, v_cnt, g_cnt, busy_p);
    chk("lock_first_valid", 32'(v_at), 10);
    idle(4);
    run_start(8, 32'hFFFF_FF00, 14, -1, -1, -1, 12, v_at, g_at, v_cnt, g_cnt, busy_p);
    chk("lock_edge_ignored", 32'(v_cnt + g_cnt), 0);
    chk("lock_busy_held", 32'(busy_p), 1);
    pulse_frame_done();
    @(negedge clk);
    chk("lock_release", 32'(busy), 0);
    step();
    idle(3);

    // async reset at tick 5 (drive cycle 7), glitch_cnt=1 beforehand
    run_start(6, 32'hFFFF_FFFE, 10, -1, -1, -1, -1, v_at, g_at, v_cnt, g_cnt, busy_p);
    idle(3);
    @(negedge clk);
    chk("pre_rst_gcnt", 32'(glitch_cnt), 1);
    step();
    run_start(8, 32'hFFFF_FF00, 20, -1, -1, 7, 9, v_at, g_at, v_cnt, g_cnt, busy_p);
    chk("rst_mid_no_pulse", 32'(v_cnt + g_cnt), 0);
    chk("rst_mid_busy", 32'(busy_p), 0);
    @(negedge clk);
    chk("rst_mid_gcnt", 32'(glitch_cnt), 0);
    chk("rst_mid_cfg_err", 32'(cfg_err), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
